// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Optional macro PS2_TX_RETRY_EN: a NACKed or timed-out byte is resent up to 3 times before tx_err.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       tx_idle
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_REL, S_DONE, S_ERR
  } state_e;

  state_e                 state_q;
  logic [7:0]             data_q;
  logic                   par_q;
  logic [3:0]             bit_q;
  logic [INH_W-1:0]       inh_q;
  logic [TMO_W-1:0]       tmo_q;
  logic                   clk_oe_q;
  logic                   dat_oe_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic                   idle_q;
  logic [SYNC_STAGES-1:0] c_sync_q;
  logic [SYNC_STAGES-1:0] d_sync_q;
  logic                   c_prev_q;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]             retry_q;
`endif

  logic ps2c_s;
  logic ps2d_s;
  logic fall_c;
  logic shift_bit_c;
  logic tmo_hit_c;
  logic nack_c;
  logic fail_c;

  // Open-collector drive: only ever pull low or float.
  assign ps2c = clk_oe_q ? 1'b0 : 1'bz;
  assign ps2d = dat_oe_q ? 1'b0 : 1'bz;

  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;
  assign tx_idle = idle_q;

  // Line synchronizers; lines idle high so reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      c_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], ps2c};
      d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], ps2d};
      c_prev_q <= c_sync_q[SYNC_STAGES-1];
    end
  end

  assign ps2c_s = c_sync_q[SYNC_STAGES-1];
  assign ps2d_s = d_sync_q[SYNC_STAGES-1];
  assign fall_c = c_prev_q & ~ps2c_s;

  // Frame bit presented after falling edge number bit_q+1: data LSB first, parity, then stop.
  always_comb begin
    shift_bit_c = 1'b1;
    if (bit_q < 4'd8) begin
      shift_bit_c = data_q[bit_q[2:0]];
    end else if (bit_q == 4'd8) begin
      shift_bit_c = par_q;
    end
  end

  // Failure detection; the timeout takes priority over any same-cycle edge.
  always_comb begin
    tmo_hit_c = 1'b0;
    nack_c    = 1'b0;
    if (state_q inside {S_SHIFT, S_ACK, S_WAIT_REL}) begin
      tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end
    if ((state_q == S_ACK) && fall_c && ps2d_s) begin
      nack_c = 1'b1;
    end
    fail_c = tmo_hit_c | nack_c;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      bit_q    <= '0;
      inh_q    <= '0;
      tmo_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      idle_q   <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (fail_c) begin
`ifdef PS2_TX_RETRY_EN
        if (retry_q != 2'd3) begin
          retry_q  <= retry_q + 2'd1;
          state_q  <= S_INHIBIT;
          inh_q    <= '0;
          bit_q    <= '0;
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
        end else begin
          retry_q  <= '0;
          state_q  <= S_ERR;
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          busy_q   <= 1'b0;
          err_q    <= 1'b1;
        end
`else
        state_q  <= S_ERR;
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        err_q    <= 1'b1;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (tx_start) begin
              data_q  <= tx_data;
              par_q   <= ~^tx_data;
              bit_q   <= '0;
              inh_q   <= '0;
              busy_q  <= 1'b1;
              idle_q  <= 1'b0;
              state_q <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (inh_q == INH_W'(INHIBIT_CYCLES)) begin
              clk_oe_q <= 1'b0;
              state_q  <= S_RTS;
            end else begin
              clk_oe_q <= 1'b1;
              inh_q    <= inh_q + 1'b1;
              if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                dat_oe_q <= 1'b1;
              end
            end
          end
          S_RTS: begin
            tmo_q   <= '0;
            state_q <= S_SHIFT;
          end
          S_SHIFT: begin
            tmo_q <= tmo_q + 1'b1;
            if (fall_c) begin
              dat_oe_q <= ~shift_bit_c;
              bit_q    <= bit_q + 4'd1;
              if (bit_q == 4'd9) begin
                state_q <= S_ACK;
              end
            end
          end
          S_ACK: begin
            tmo_q <= tmo_q + 1'b1;
            if (fall_c) begin
              state_q <= S_WAIT_REL;
            end
          end
          S_WAIT_REL: begin
            tmo_q <= tmo_q + 1'b1;
            if (ps2c_s && ps2d_s) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`ifdef PS2_TX_RETRY_EN
              retry_q <= '0;
`endif
            end
          end
          S_DONE: begin
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          S_ERR: begin
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
